ahb_resp_mux_ctrl: RTL

//   Data-phase controller for the 4-slave AHB-lite interconnect. Drives the 2-bit slave-select into

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_resp_mux_ctrl_if.sv | 32 +++
 rtl/ahb_default_slave.sv | 42 ++++
 rtl/ahb_resp_mux_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite constants and the default-slave state type for the response mux slice.
// Pure declarations: no logic, no latency, no flow control.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;
endpackage

// File: rtl/ahb_resp_mux_ctrl_if.sv
// Bus bundle between the master/slaves side and the response mux; master = bus side, slave = mux.
// Wires only: zero latency; backpressure travels as HREADYOUT_n in and HREADY out.
interface ahb_resp_mux_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [1:0]        sel;
  logic              HREADYOUT_1, HREADYOUT_2, HREADYOUT_3, HREADYOUT_4;
  logic              HRESP_1, HRESP_2, HRESP_3, HRESP_4;
  logic [DATA_W-1:0] HRDATA_1, HRDATA_2, HRDATA_3, HRDATA_4;
  logic              HREADY;
  logic              HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    output HADDR, HTRANS,
    output HREADYOUT_1, HREADYOUT_2, HREADYOUT_3, HREADYOUT_4,
    output HRESP_1, HRESP_2, HRESP_3, HRESP_4,
    output HRDATA_1, HRDATA_2, HRDATA_3, HRDATA_4,
    input  sel, HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS,
    input  HREADYOUT_1, HREADYOUT_2, HREADYOUT_3, HREADYOUT_4,
    input  HRESP_1, HRESP_2, HRESP_3, HRESP_4,
    input  HRDATA_1, HRDATA_2, HRDATA_3, HRDATA_4,
    output sel, HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave answering disabled slots with the two-cycle AHB ERROR (ERR1 wait, ERR2 done).
// Outputs follow state combinationally; advances only on address phases accepted with HREADY=1.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic HREADY,
  input  logic err_req,
  output logic ds_ready,
  output logic ds_resp
);

  ds_state_e state_q, state_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (HREADY && err_req) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      // ERR2 completes the error, so the next address phase is accepted here.
      DS_ERR2: if (HREADY) state_d = err_req ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    ds_ready = 1'b1;
    ds_resp  = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin ds_ready = 1'b0; ds_resp = HRESP_ERROR; end
      DS_ERR2: begin ds_ready = 1'b1; ds_resp = HRESP_ERROR; end
      default: begin ds_ready = 1'b1; ds_resp = HRESP_OKAY;  end
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux_ctrl.sv
// Data-phase owner register and HREADY/HRESP/HRDATA return mux for a 4-slot AHB-lite fabric.
// sel is 0-latency from HADDR; owner updates only on HREADY=1 edges, so slave waits hold the mux.
module ahb_resp_mux_ctrl
  import ahb_pkg::*;
#(
  parameter int                   ADDR_W = 32,
  parameter int                   DATA_W = 32,
  parameter logic [NUM_SLOTS-1:0] SLV_EN = 4'b1111
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_resp_mux_ctrl_if.slave  bus
);

  logic [1:0]        dp_sel_q, dp_sel_d;
  logic              dp_act_q, dp_act_d;
  logic              dp_err_q, dp_err_d;
  logic              err_req;
  logic              hready;
  logic              ds_ready, ds_resp;
  logic              slv_rdy, slv_rsp;
  logic [DATA_W-1:0] slv_rdata;

  assign bus.sel = bus.HADDR[ADDR_W-1 -: 2];
  assign err_req = bus.HTRANS[1] & ~SLV_EN[bus.sel];

  always_comb begin
    dp_sel_d = dp_sel_q;
    dp_act_d = dp_act_q;
    dp_err_d = dp_err_q;
    if (hready) begin
      dp_sel_d = bus.sel;
      dp_act_d = bus.HTRANS[1];
      dp_err_d = err_req;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_sel_q <= 2'd0;
      dp_act_q <= 1'b0;
      dp_err_q <= 1'b0;
    end else begin
      dp_sel_q <= dp_sel_d;
      dp_act_q <= dp_act_d;
      dp_err_q <= dp_err_d;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HREADY   (hready),
    .err_req  (err_req),
    .ds_ready (ds_ready),
    .ds_resp  (ds_resp)
  );

  always_comb begin
    slv_rdy   = bus.HREADYOUT_1;
    slv_rsp   = bus.HRESP_1;
    slv_rdata = bus.HRDATA_1;
    case (dp_sel_q)
      2'd1: begin slv_rdy = bus.HREADYOUT_2; slv_rsp = bus.HRESP_2; slv_rdata = bus.HRDATA_2; end
      2'd2: begin slv_rdy = bus.HREADYOUT_3; slv_rsp = bus.HRESP_3; slv_rdata = bus.HRDATA_3; end
      2'd3: begin slv_rdy = bus.HREADYOUT_4; slv_rsp = bus.HRESP_4; slv_rdata = bus.HRDATA_4; end
      default: ;
    endcase
  end

  // Slave responses pass through unchecked; only disabled slots are answered locally.
  always_comb begin
    hready     = 1'b1;
    bus.HRESP  = HRESP_OKAY;
    bus.HRDATA = '0;
    if (dp_act_q && dp_err_q) begin
      hready    = ds_ready;
      bus.HRESP = ds_resp;
    end else if (dp_act_q && SLV_EN[dp_sel_q]) begin
      hready     = slv_rdy;
      bus.HRESP  = slv_rsp;
      bus.HRDATA = slv_rdata;
    end
  end

  assign bus.HREADY = hready;

endmodule
